// File: rtl/rot_coeff_gen.sv
// Builds R = Rx(pitch)*Rz(yaw) in Q1.6 from a quarter-wave sine ROM,
// double-buffered so the active set only changes on a frame_sync.
module rot_coeff_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] yaw,
  input  logic [7:0] pitch,
  input  logic       frame_sync,
  output logic       busy,
  output logic       done,
  output logic [7:0] c00,
  output logic [7:0] c01,
  output logic [7:0] c02,
  output logic [7:0] c10,
  output logic [7:0] c11,
  output logic [7:0] c12,
  output logic [7:0] c20,
  output logic [7:0] c21,
  output logic [7:0] c22,
  output logic       coeff_update
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MULT,
    WRITE
  } state_t;

  // packed {c22,c21,c20,c12,c11,c10,c02,c01,c00}
  localparam logic [71:0] IDENT = {
    8'd64, 8'd0, 8'd0,
    8'd0, 8'd64, 8'd0,
    8'd0, 8'd0, 8'd64
  };

  localparam logic [6:0] SIN_Q [0:64] = '{
    7'd0,  7'd2,  7'd3,  7'd5,  7'd6,  7'd8,  7'd9,  7'd11,
    7'd12, 7'd14, 7'd16, 7'd17, 7'd19, 7'd20, 7'd22, 7'd23,
    7'd24, 7'd26, 7'd27, 7'd29, 7'd30, 7'd32, 7'd33, 7'd34,
    7'd36, 7'd37, 7'd38, 7'd39, 7'd41, 7'd42, 7'd43, 7'd44,
    7'd45, 7'd46, 7'd47, 7'd48, 7'd49, 7'd50, 7'd51, 7'd52,
    7'd53, 7'd54, 7'd55, 7'd56, 7'd56, 7'd57, 7'd58, 7'd59,
    7'd59, 7'd60, 7'd60, 7'd61, 7'd61, 7'd62, 7'd62, 7'd62,
    7'd63, 7'd63, 7'd63, 7'd64, 7'd64, 7'd64, 7'd64, 7'd64,
    7'd64
  };

  state_t r_state;
  state_t w_next;
  logic [1:0] r_cnt;

  logic [7:0] r_yaw, r_pitch;
  logic [7:0] r_sy, r_cy, r_sp, r_cp;
  logic [7:0] r_p0, r_p1, r_p2, r_p3;
  logic [6:0] r_rom;
  logic       r_neg;
  logic [71:0] r_sh, r_act;
  logic r_pend, r_done, r_upd;

  logic [7:0] w_ang;
  logic [6:0] w_idx;
  logic [7:0] w_mag, w_sin;
  logic [7:0] w_ma, w_mb;
  logic signed [15:0] w_full;
  logic [7:0] w_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state != w_next) ? 2'd0 : r_cnt + 2'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = LOOKUP;
      LOOKUP:  if (r_cnt == 2'd3) w_next = MULT;
      MULT:    if (r_cnt == 2'd3) w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ROM address runs one step ahead: sy is fetched on the accept edge
  always_comb begin
    w_ang = yaw;
    if (r_state == LOOKUP) begin
      unique case (r_cnt)
        2'd0:    w_ang = r_yaw + 8'd64;
        2'd1:    w_ang = r_pitch;
        2'd2:    w_ang = r_pitch + 8'd64;
        default: w_ang = r_pitch;
      endcase
    end
  end

  assign w_idx = w_ang[6] ? 7'd64 - {1'b0, w_ang[5:0]}
                          : {1'b0, w_ang[5:0]};
  assign w_mag = {1'b0, r_rom};
  assign w_sin = r_neg ? 8'(-w_mag) : w_mag;

  assign w_ma   = r_cnt[1] ? r_sp : r_cp;
  assign w_mb   = r_cnt[0] ? r_cy : r_sy;
  assign w_full = 16'($signed(w_ma)) * 16'($signed(w_mb)) + 16'sd32;
  assign w_prod = 8'(w_full >>> 6);

  always_ff @(posedge clk) begin
    r_rom <= SIN_Q[w_idx];
    r_neg <= w_ang[7];
    if (r_state == IDLE && start) begin
      r_yaw   <= yaw;
      r_pitch <= pitch;
    end
    if (r_state == LOOKUP) begin
      unique case (r_cnt)
        2'd0:    r_sy <= w_sin;
        2'd1:    r_cy <= w_sin;
        2'd2:    r_sp <= w_sin;
        default: r_cp <= w_sin;
      endcase
    end
    if (r_state == MULT) begin
      unique case (r_cnt)
        2'd0:    r_p0 <= w_prod;
        2'd1:    r_p1 <= w_prod;
        2'd2:    r_p2 <= w_prod;
        default: r_p3 <= w_prod;
      endcase
    end
  end

  // transfer reads the old shadow, so a coincident WRITE lands after it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
      r_upd  <= 1'b0;
      r_pend <= 1'b0;
      r_sh   <= IDENT;
      r_act  <= IDENT;
    end else begin
      r_done <= (r_state == WRITE);
      r_upd  <= frame_sync && r_pend;
      if (frame_sync && r_pend) begin
        r_act  <= r_sh;
        r_pend <= 1'b0;
      end
      if (r_state == WRITE) begin
        r_sh <= {r_cp, r_p3, r_p2,
                 8'(-r_sp), r_p1, r_p0,
                 8'd0, 8'(-r_sy), r_cy};
        r_pend <= 1'b1;
      end
    end
  end

  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign coeff_update = r_upd;

  assign c00 = r_act[7:0];
  assign c01 = r_act[15:8];
  assign c02 = r_act[23:16];
  assign c10 = r_act[31:24];
  assign c11 = r_act[39:32];
  assign c12 = r_act[47:40];
  assign c20 = r_act[55:48];
  assign c21 = r_act[63:56];
  assign c22 = r_act[71:64];

endmodule

// File: tb/tb_rot_coeff_gen.sv
// Self-checking bench for rot_coeff_gen: vector table plus
// hand-written handshake and buffering sequences.
module tb_rot_coeff_gen;

  logic clk = 1'b0;
  logic reset, start, frame_sync;
  logic [7:0] yaw, pitch;
  logic busy, done, coeff_update;
  logic [7:0] c00, c01, c02, c10, c11, c12, c20, c21, c22;
  logic [71:0] act;

  always #5 clk = ~clk;

  rot_coeff_gen dut (
    .clk(clk), .reset(reset), .start(start),
    .yaw(yaw), .pitch(pitch), .frame_sync(frame_sync),
    .busy(busy), .done(done),
    .c00(c00), .c01(c01), .c02(c02),
    .c10(c10), .c11(c11), .c12(c12),
    .c20(c20), .c21(c21), .c22(c22),
    .coeff_update(coeff_update)
  );

  assign act = {c22, c21, c20, c12, c11, c10, c02, c01, c00};

  localparam logic [71:0] IDENT = {
    8'd64, 8'd0, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd0, 8'd64};

  typedef struct {
    logic [7:0]  y;
    logic [7:0]  p;
    logic [71:0] exp;
  } vec_t;

  vec_t tab [12];
  int n_tests = 0;
  int n_fail  = 0;

  // reference: real-valued trig, rounded to Q1.6
  function automatic int qsin(int a);
    real x;
    x = 64.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
    if (x >= 0.0) return $rtoi($floor(x + 0.5));
    return -$rtoi($floor(-x + 0.5));
  endfunction

  function automatic int qmul(int a, int b);
    return (a * b + 32) >>> 6;
  endfunction

  function automatic logic [71:0] model(int y, int p);
    int sy, cy, sp, cp;
    sy = qsin(y);
    cy = qsin((y + 64) % 256);
    sp = qsin(p);
    cp = qsin((p + 64) % 256);
    return {8'(cp), 8'(qmul(sp, cy)), 8'(qmul(sp, sy)),
            8'(-sp), 8'(qmul(cp, cy)), 8'(qmul(cp, sy)),
            8'd0, 8'(-sy), 8'(cy)};
  endfunction

  task automatic chk(input string nm, input logic [71:0] got,
                     input logic [71:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fsync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic build(input logic [7:0] y, input logic [7:0] p);
    bit seen;
    seen = 1'b0;
    yaw = y;
    pitch = p;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      seen = done;
    end
    chk("done_seen", 72'(seen), 72'd1);
  endtask

  logic [71:0] m64, m32, prev;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    frame_sync = 1'b0;
    yaw = 8'd0;
    pitch = 8'd0;
    m64 = {8'd64, 8'd0, 8'd0, 8'd0, 8'd0, 8'd64, 8'd0, 8'hC0, 8'd0};
    m32 = {8'd45, 8'd32, 8'd32, 8'hD3, 8'd32, 8'd32, 8'd0, 8'hD3, 8'd45};
    tab[0] = '{8'd64, 8'd0, m64};
    tab[1] = '{8'd0, 8'd64,
               {8'd0, 8'd64, 8'd0, 8'hC0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd64}};
    tab[2] = '{8'd32, 8'd32, m32};
    tab[3] = '{8'd0, 8'd0, IDENT};
    for (int i = 4; i < 12; i++) begin
      tab[i].y = 8'($urandom_range(0, 255));
      tab[i].p = 8'($urandom_range(0, 255));
      tab[i].exp = model(int'(tab[i].y), int'(tab[i].p));
    end

    // reset state
    tick();
    tick();
    chk("rst_coeff", act, IDENT);
    chk("rst_flags", {busy, done, coeff_update}, 72'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_coeff", act, IDENT);
      chk("idle_flags", {busy, done, coeff_update}, 72'd0);
    end

    // latency, and a start pulse mid-build that must be ignored
    yaw = 8'd64;
    pitch = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      start = (k == 3);
      tick();
      chk($sformatf("busy_n%0d", k), 72'(busy), 72'(k <= 8));
      chk($sformatf("done_n%0d", k), 72'(done), 72'(k == 9));
    end
    start = 1'b0;
    chk("act_hold", act, IDENT);
    chk("upd_hold", 72'(coeff_update), 72'd0);
    fsync();
    chk("upd_pulse", 72'(coeff_update), 72'd1);
    chk("act_y64", act, m64);
    tick();
    chk("upd_once", 72'(coeff_update), 72'd0);

    // vector table
    for (int i = 0; i < 12; i++) begin
      prev = act;
      build(tab[i].y, tab[i].p);
      chk($sformatf("vec%0d_hold", i), act, prev);
      fsync();
      chk($sformatf("vec%0d_upd", i), 72'(coeff_update), 72'd1);
      chk($sformatf("vec%0d_y%0d_p%0d", i, tab[i].y, tab[i].p),
          act, tab[i].exp);
      tick();
    end

    // start held high: one build per 10 cycles
    yaw = 8'd32;
    pitch = 8'd32;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("cont_done%0d", k), 72'(done),
          72'(k == 9 || k == 19));
    end
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    fsync();
    chk("cont_act", act, m32);

    // reset mid-build aborts everything
    yaw = 8'd64;
    pitch = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_coeff", act, IDENT);
    chk("abort_busy", 72'(busy), 72'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("abort_nodone", 72'(done | busy), 72'd0);
    end
    fsync();
    chk("abort_noupd", 72'(coeff_update), 72'd0);
    chk("abort_act", act, IDENT);

    // start on first cycle after reset release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("rel_done%0d", k), 72'(done), 72'(k == 9));
    end
    fsync();
    chk("rel_act", act, m64);
    tick();

    // two pending builds, second WRITE coincides with frame_sync
    build(8'd32, 8'd32);
    yaw = 8'd0;
    pitch = 8'd64;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("coin_done", 72'(done), 72'd1);
    chk("coin_upd", 72'(coeff_update), 72'd1);
    chk("coin_first", act, m32);
    tick();
    chk("coin_upd_off", 72'(coeff_update), 72'd0);
    fsync();
    chk("coin_second", act, tab[1].exp);
    chk("coin_upd2", 72'(coeff_update), 72'd1);
    tick();

    // WRITE with frame_sync and nothing pending: no transfer
    yaw = 8'd64;
    pitch = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("nopend_done", 72'(done), 72'd1);
    chk("nopend_upd", 72'(coeff_update), 72'd0);
    chk("nopend_act", act, tab[1].exp);
    tick();
    fsync();
    chk("nopend_later", act, m64);
    chk("nopend_upd2", 72'(coeff_update), 72'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rot_coeff_gen.md
ROT_COEFF_GEN -- requirements
Module: rot_coeff_gen

Interface
REQ-001 clk  input  1  single clock; every register updates on the rising edge.
REQ-002 reset  input  1  reset is synchronous and active-high.
REQ-003 start  input  1  request to build a new matrix; sampled only in IDLE.
REQ-004 yaw  input  8  unsigned angle about Z, 256 steps per revolution; captured when start is accepted.
REQ-005 pitch  input  8  unsigned angle about X, same encoding; captured when start is accepted.
REQ-006 frame_sync  input  1  frame-boundary strobe; permits a pending matrix to go active.
REQ-007 busy  output  1  high while a computation is in progress.
REQ-008 done  output  1  one-cycle pulse when the shadow matrix has been written.
REQ-009 c00,c01,c02,c10,c11,c12,c20,c21,c22  output  8 each  active coefficients, signed Q1.6 (64 = +1.0); row r drives one per-axis rotate stage (coeff1..3 = cr0..cr2).
REQ-010 coeff_update  output  1  one-cycle pulse on the cycle after the active set changes.

Function
REQ-011 The matrix SHALL be R = Rx(pitch)*Rz(yaw): row0 = (cy, -sy, 0); row1 = (cp*sy, cp*cy, -sp); row2 = (sp*sy, sp*cy, cp), with s/c = sin/cos of the angle.
REQ-012 sin(a) SHALL come from a synchronous quarter-wave ROM of 65 entries, round(64*sin(2*pi*k/256)) for k = 0..64; other quadrants come from symmetry; cos(a) = sin(a+64 mod 256).
REQ-013 A product SHALL be (a*b + 32) >>> 6, using a 16-bit signed intermediate and truncation to 8 bits; no saturation, since |a|,|b| <= 64.
REQ-014 Negation SHALL be two's complement of the 8-bit value; operands are at most 64 in magnitude, so negation cannot overflow.
REQ-015 The FSM states SHALL be IDLE -> LOOKUP (4 cycles: sy, cy, sp, cp) -> MULT (4 cycles, one shared multiplier: cp*sy, cp*cy, sp*sy, sp*cy) -> WRITE (1 cycle) -> IDLE.
REQ-016 If start is high at edge N in IDLE: busy SHALL be 1 from N+1 through N+8; at edge N+9 the shadow set is written, done = 1 for one cycle, busy = 0, and the state is IDLE.
REQ-017 start SHALL be ignored while busy; it has no queueing and no effect on the current computation.
REQ-018 A WRITE SHALL set the pending flag; if pending is already set, the shadow set is overwritten and pending stays set.
REQ-019 If frame_sync = 1 and pending = 1 at an edge, the active set SHALL load from shadow, pending SHALL clear, and coeff_update SHALL pulse on the next cycle.
REQ-020 If frame_sync coincides with the WRITE edge and pending was 0, there SHALL be no transfer; pending becomes 1 and the set waits for the next frame_sync.
REQ-021 If frame_sync coincides with the WRITE edge and pending was 1, the previously pending shadow SHALL transfer first; the new set is then written to shadow, pending stays 1, and coeff_update pulses.
REQ-022 The active coefficients SHALL change only on a frame_sync transfer or on reset.
REQ-023 start may be accepted again on the cycle after done; back-to-back builds are one per 10 cycles.

Reset
REQ-024 While reset = 1: state = IDLE, busy = 0, done = 0, coeff_update = 0, pending = 0.
REQ-025 While reset = 1: active and shadow sets = identity (c00 = c11 = c22 = 64, all other coefficients 0).
REQ-026 Reset during LOOKUP/MULT/WRITE SHALL abort the computation, with no done pulse and no shadow or active update; start is accepted on the first cycle after reset is released.

Verification
REQ-027 Release reset, no start -> outputs hold identity; busy/done/coeff_update stay 0 for 100 cycles.
REQ-028 yaw = 64, pitch = 0, start at N -> done at N+9; active set unchanged; then frame_sync -> row0 (0,-64,0), row1 (64,0,0), row2 (0,0,64), coeff_update pulses once.
REQ-029 yaw = 0, pitch = 64, then frame_sync -> row0 (64,0,0), row1 (0,0,-64), row2 (0,64,0).
REQ-030 yaw = 32, pitch = 32, then frame_sync -> row0 (45,-45,0), row1 (32,32,-45), row2 (32,32,45).
REQ-031 start held high continuously -> done at N+9, N+19, ...; start pulse at N+3 ignored; assert reset at N+5 -> no done, identity retained.
REQ-032 Two builds without frame_sync, second done coincident with frame_sync -> first set goes active, second set remains pending until the next frame_sync.
